fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequential fetch controller that owns the program counter and drives the instruction-fetch stage. It applies next-PC selection (sequential `pc+4`, conditional branch, register jump, immediate jump) and runs the request/acknowledge handshake with instruction memory. It presents fetched instructions to ID through a one-entry skid buffer that absorbs stalls, flushes on redirect, and optionally takes interrupts.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- INT_VECTOR, 32'h0000_0008, interrupt entry address

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  ID hazard stall; holds IF output, blocks redirects
- pc_source  in  2  00 seq, 01 condit_bran_pc, 10 j_reg_pc, 11 j_pc; non-zero = redirect request
- condit_bran_pc, j_reg_pc, j_pc  in  32 each  redirect targets, valid with pc_source
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- if_inst  out  32  instruction to ID
- if_pc  out  32  address of if_inst
- if_valid  out  1  if_inst is a live instruction
- int_req  in  1  level interrupt request
- eret  in  1  one-cycle return-from-interrupt pulse
- int_ack  out  1  one-cycle pulse on interrupt entry
- epc  out  32  saved return PC

## Operation
- Reset values: pc=RESET_PC, state=BOOT, imem_req=0, if_inst=0, if_pc=0, if_valid=0, int_ack=0, epc=0, mask=0, pending redirect cleared.
- States:
  - BOOT: one cycle, req=0, redirects ignored; moves to FETCH.
  - FETCH: req=1, addr=pc held stable until ack.
  - HOLD: req=0, skid buffer full.
- FETCH, ack & !stall & no kill: if_inst/if_pc/if_valid ← rdata/pc/1; pc ← pc+4; stay in FETCH.
- FETCH, ack & stall: rdata/pc go to the skid buffer; outputs hold; go to HOLD.
- HOLD & !stall: skid buffer drives the outputs; pc ← pc+4; go to FETCH.
- Redirect is accepted only when pc_source≠00 and stall=0, in FETCH or HOLD. Target is chosen by pc_source.
  - Accepted redirect clears if_valid and the skid buffer.
  - Ack in the same cycle: data dropped, pc ← target.
  - No ack in that cycle: target latched as pending and kill set. The next ack is dropped, then pc ← pending.
  - A later redirect overwrites the pending target.
  - A redirect accepted in HOLD goes to FETCH with pc ← target.
- Branches have no delay slot. pc+4 wraps modulo 2^32.

## Timing
- Ack in cycle N → if_valid/if_inst visible at N+1, and imem_addr updates at N+1.
- Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
- Redirect accepted in cycle N → if_valid=0 at N+1.
  - With ack at N: target address on imem_addr at N+1.
  - Otherwise: target address on the cycle after the dropped ack.
- rst asserted mid-fetch: immediate return to reset values. An outstanding ack is not tracked; memory must drop it.
- stall does not gate imem_req while in FETCH.

## Configuration
- FETCH_INT_EN defined:
  - Interrupt is taken on FETCH ack when int_req & !mask & !stall & no redirect/kill.
  - On entry: the fetched word is dropped, epc ← pc of the dropped word, pc ← INT_VECTOR, if_valid ← 0, int_ack=1 for one cycle, mask ← 1.
  - eret with stall=0 acts as a redirect to epc and clears mask.
  - Priority: redirect > eret > interrupt.
- FETCH_INT_EN undefined: int_req and eret ignored; int_ack=0; epc=0; ports retained.

## Test plan
- Reset release, zero-wait memory with ack tied to req: imem_addr 0,4,8,C on consecutive cycles; if_pc trails by one cycle; if_valid=1 from cycle 2.
- Sequential fetch with ack at addr 8 while stall=1 for 3 cycles: state enters HOLD, req=0, outputs frozen on addr 4. Stall drop presents addr 8 next cycle; next fetch is addr C.
- Redirect pc_source=11, j_pc=0x100 with ack absent, ack 2 cycles later: that ack is dropped, if_valid=0, next imem_addr=0x100.
- pc_source=01 together with ack at 0x20, condit_bran_pc=0x40: 0x20 never valid; imem_addr=0x40 next cycle; redirect with stall=1 has no effect.
- FETCH_INT_EN on, int_req at fetch of 0x30: int_ack pulse, epc=0x30, imem_addr=0x8. A second int_req is ignored until eret, which gives imem_addr=0x30.
- pc=0xFFFF_FFFC sequential: next imem_addr=0x0000_0000. Async rst mid-wait: imem_req=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: control inputs, instruction-memory handshake, IF->ID outputs
// and interrupt signals. master = fetch_ctrl side, slave = environment side.
interface fetch_if;
    logic        stall;
    logic [1:0]  pc_source;
    logic [31:0] condit_bran_pc;
    logic [31:0] j_reg_pc;
    logic [31:0] j_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        int_req;
    logic        eret;
    logic        int_ack;
    logic [31:0] epc;

    modport master (
        input  stall, pc_source, condit_bran_pc, j_reg_pc, j_pc,
               imem_ack, imem_rdata, int_req, eret,
        output imem_req, imem_addr, if_inst, if_pc, if_valid, int_ack, epc
    );

    modport slave (
        output stall, pc_source, condit_bran_pc, j_reg_pc, j_pc,
               imem_ack, imem_rdata, int_req, eret,
        input  imem_req, imem_addr, if_inst, if_pc, if_valid, int_ack, epc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, runs the imem req/ack handshake and feeds ID through
// a one-entry skid buffer. Interrupt support is enabled by defining FETCH_INT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0008
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int unsigned XLEN = 32;

`ifdef FETCH_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_req;
    logic [XLEN-1:0] r_if_inst, w_if_inst_nxt;
    logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
    logic            r_if_valid, w_if_valid_nxt;
    logic [XLEN-1:0] r_skid_inst, w_skid_nxt;
    logic            r_kill, w_kill_nxt;
    logic [XLEN-1:0] r_pend_pc, w_pend_nxt;
    logic            r_int_ack, w_int_ack_nxt;
    logic [XLEN-1:0] r_epc, w_epc_nxt;
    logic            r_mask, w_mask_nxt;

    logic            w_active;
    logic            w_redir;
    logic            w_eret_take;
    logic            w_int_take;
    logic            w_take;
    logic [XLEN-1:0] w_sel_tgt;
    logic [XLEN-1:0] w_tgt;

    // Redirect arbitration: branch/jump beats eret; eret beats interrupt
    assign w_active    = (r_state != S_BOOT);
    assign w_redir     = w_active && (bus.pc_source != 2'b00) && !bus.stall;
    assign w_eret_take = INT_EN && w_active && bus.eret && !bus.stall && !w_redir;
    assign w_int_take  = INT_EN && bus.int_req && !r_mask && !bus.stall;
    assign w_take      = w_redir || w_eret_take;
    assign w_tgt       = w_redir ? w_sel_tgt : r_epc;

    always_comb begin
        w_sel_tgt = bus.j_pc;
        unique case (bus.pc_source)
            2'b01:   w_sel_tgt = bus.condit_bran_pc;
            2'b10:   w_sel_tgt = bus.j_reg_pc;
            default: w_sel_tgt = bus.j_pc;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_inst_nxt  = r_if_inst;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        w_skid_nxt     = r_skid_inst;
        w_kill_nxt     = r_kill;
        w_pend_nxt     = r_pend_pc;
        w_int_ack_nxt  = 1'b0;
        w_epc_nxt      = r_epc;
        w_mask_nxt     = r_mask;

        if (w_eret_take) w_mask_nxt = 1'b0;

        unique case (r_state)
            S_BOOT: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_take) begin
                    w_if_valid_nxt = 1'b0;
                    if (bus.imem_ack) begin
                        w_pc_nxt   = w_tgt;
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_pend_nxt = w_tgt;
                        w_kill_nxt = 1'b1;
                    end
                end else if (bus.imem_ack && r_kill) begin
                    // Word belongs to the abandoned path
                    w_pc_nxt   = r_pend_pc;
                    w_kill_nxt = 1'b0;
                end else if (bus.imem_ack && w_int_take) begin
                    w_if_valid_nxt = 1'b0;
                    w_epc_nxt      = r_pc;
                    w_pc_nxt       = INT_VECTOR;
                    w_int_ack_nxt  = 1'b1;
                    w_mask_nxt     = 1'b1;
                end else if (bus.imem_ack && !bus.stall) begin
                    w_if_inst_nxt  = bus.imem_rdata;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + XLEN'(4);
                end else if (bus.imem_ack) begin
                    w_skid_nxt  = bus.imem_rdata;
                    w_state_nxt = S_HOLD;
                end else if (!bus.stall) begin
                    // ID consumed the last word and nothing new arrived
                    w_if_valid_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                if (w_take) begin
                    w_pc_nxt       = w_tgt;
                    w_if_valid_nxt = 1'b0;
                    w_kill_nxt     = 1'b0;
                    w_state_nxt    = S_FETCH;
                end else if (!bus.stall) begin
                    w_if_inst_nxt  = r_skid_inst;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + XLEN'(4);
                    w_state_nxt    = S_FETCH;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_if_inst   <= '0;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
            r_skid_inst <= '0;
            r_kill      <= 1'b0;
            r_pend_pc   <= '0;
            r_int_ack   <= 1'b0;
            r_epc       <= '0;
            r_mask      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req       <= (w_state_nxt == S_FETCH);
            r_if_inst   <= w_if_inst_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_skid_inst <= w_skid_nxt;
            r_kill      <= w_kill_nxt;
            r_pend_pc   <= w_pend_nxt;
            r_int_ack   <= w_int_ack_nxt;
            r_epc       <= w_epc_nxt;
            r_mask      <= w_mask_nxt;
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign bus.if_inst   = r_if_inst;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.int_ack   = r_int_ack;
    assign bus.epc       = r_epc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] IVEC   = 32'h0000_0008;

`ifdef FETCH_INT_EN
    localparam bit INT_ON = 1'b1;
`else
    localparam bit INT_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    fetch_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC), .INT_VECTOR(IVEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: skid buffer and pending redirect kept as queues
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_skid[$];
    logic [31:0] m_pend[$];
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    bit          m_int_ack;
    logic [31:0] m_epc;
    bit          m_mask;

    logic [31:0] t_cb, t_jr, t_j;

    task automatic model_reset();
        m_boot = 1; m_pc = RST_PC; m_skid.delete(); m_pend.delete();
        m_valid = 0; m_inst = '0; m_ipc = '0; m_int_ack = 0; m_epc = '0; m_mask = 0;
    endtask

    task automatic model_step(input bit stall, input logic [1:0] src, input bit ack,
                              input logic [31:0] rdata, input bit irq, input bit er);
        bit          redir;
        logic [31:0] tgt;
        m_int_ack = 0;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        redir = (src != 2'b00) && !stall;
        tgt   = (src == 2'b01) ? t_cb : (src == 2'b10) ? t_jr : t_j;
        if (!redir && INT_ON && er && !stall) begin
            redir  = 1;
            tgt    = m_epc;
            m_mask = 0;
        end
        if (m_skid.size() != 0) begin
            if (redir) begin
                m_skid.delete(); m_valid = 0; m_pc = tgt; m_pend.delete();
            end else if (!stall) begin
                m_inst = m_skid.pop_front(); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            end
        end else begin
            if (redir) begin
                m_valid = 0;
                m_pend.delete();
                if (ack) m_pc = tgt;
                else     m_pend.push_back(tgt);
            end else if (ack && m_pend.size() != 0) begin
                m_pc = m_pend.pop_front();
            end else if (ack && INT_ON && irq && !m_mask && !stall) begin
                m_valid = 0; m_epc = m_pc; m_pc = IVEC; m_int_ack = 1; m_mask = 1;
            end else if (ack && !stall) begin
                m_inst = rdata; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            end else if (ack) begin
                m_skid.push_back(rdata);
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    // One clock: drive at negedge, compare against model, advance model, wait next negedge
    task automatic run_cycle(input bit stall, input logic [1:0] src, input bit ack,
                             input bit irq, input bit er);
        bit          eff_ack;
        logic [31:0] rd;
        eff_ack = ack && bus.imem_req;
        rd      = mem_word(bus.imem_addr);
        bus.stall = stall; bus.pc_source = src; bus.imem_ack = eff_ack; bus.imem_rdata = rd;
        bus.int_req = irq; bus.eret = er;
        bus.condit_bran_pc = t_cb; bus.j_reg_pc = t_jr; bus.j_pc = t_j;
        #1;
        chk("req", {31'd0, bus.imem_req}, {31'd0, !m_boot && m_skid.size() == 0});
        chk("addr", bus.imem_addr, m_pc);
        chk("valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
        chk("int_ack", {31'd0, bus.int_ack}, {31'd0, m_int_ack});
        chk("epc", bus.epc, m_epc);
        if (m_valid) begin
            chk("if_inst", bus.if_inst, m_inst);
            chk("if_pc", bus.if_pc, m_ipc);
        end
        model_step(stall, src, eff_ack, rd, irq, er);
        @(negedge clk);
    endtask

    initial begin
        t_cb = '0; t_jr = '0; t_j = '0;
        bus.stall = 0; bus.pc_source = 2'b00; bus.imem_ack = 0; bus.imem_rdata = '0;
        bus.int_req = 0; bus.eret = 0;
        bus.condit_bran_pc = '0; bus.j_reg_pc = '0; bus.j_pc = '0;
        rst = 1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_inst", bus.if_inst, 32'd0);
        chk("rst_ifpc", bus.if_pc, 32'd0);
        chk("rst_epc", bus.epc, 32'd0);
        rst = 0;

        // Zero-wait memory: one instruction per cycle after the boot cycle
        for (int i = 0; i < 5; i++) begin
            if (i > 0) chk("zw_addr", bus.imem_addr, 32'(4 * (i - 1)));
            if (i > 1) chk("zw_ifpc", bus.if_pc, 32'(4 * (i - 2)));
            run_cycle(0, 2'b00, 1, 0, 0);
        end

        // Ack under stall parks the word in the skid buffer
        run_cycle(1, 2'b00, 1, 0, 0);
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        run_cycle(1, 2'b00, 1, 0, 0);
        run_cycle(1, 2'b00, 1, 0, 0);
        run_cycle(0, 2'b00, 1, 0, 0);
        chk("skid_ifpc", bus.if_pc, 32'h10);
        chk("skid_next", bus.imem_addr, 32'h14);

        // Jump with no ack; the ack two cycles later is dropped
        t_j = 32'h100;
        run_cycle(0, 2'b11, 0, 0, 0);
        run_cycle(0, 2'b00, 0, 0, 0);
        run_cycle(0, 2'b00, 1, 0, 0);
        chk("kill_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("kill_addr", bus.imem_addr, 32'h100);

        // Branch together with ack; stalled redirect is ignored
        t_cb = 32'h40;
        run_cycle(1, 2'b01, 0, 0, 0);
        chk("stall_redir", bus.imem_addr, 32'h100);
        run_cycle(0, 2'b01, 1, 0, 0);
        chk("br_addr", bus.imem_addr, 32'h40);
        chk("br_valid", {31'd0, bus.if_valid}, 32'd0);

        // PC wrap
        t_j = 32'hFFFF_FFFC;
        run_cycle(0, 2'b11, 1, 0, 0);
        chk("wrap_pre", bus.imem_addr, 32'hFFFF_FFFC);
        run_cycle(0, 2'b00, 1, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // Asynchronous reset while waiting on memory
        run_cycle(0, 2'b00, 0, 0, 0);
        bus.imem_ack = 0;
        #1 rst = 1;
        #1;
        chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("arst_addr", bus.imem_addr, RST_PC);
        model_reset();
        @(negedge clk);
        rst = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          s, a, irq, er;
            logic [1:0]  src;
            t_cb = $urandom & 32'hFFFF_FFFC;
            t_jr = $urandom & 32'hFFFF_FFFC;
            t_j  = $urandom & 32'hFFFF_FFFC;
            s    = ($urandom_range(0, 3) == 0);
            a    = ($urandom_range(0, 9) < 6);
            irq  = ($urandom_range(0, 4) == 0);
            er   = ($urandom_range(0, 19) == 0);
            src  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_cycle(s, src, a, irq, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
